// File: rtl/fir_mac_engine.sv
// T-tap FIR engine: streams samples through a circular history RAM and a tap RAM, one MAC per cycle.
// Latency: sample accepted in cycle c gives a result in cycle c+T+2; one sample per T+3 cycles at best.
// Backpressure: the result stays held in OUT until sm_tready, and ss_tready is low outside IN.
module fir_mac_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TAP_NUM    = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic [31:0]           data_length,
  input  logic                  ss_tvalid,
  input  logic [DATA_WIDTH-1:0] ss_tdata,
  input  logic                  ss_tlast,
  output logic                  ss_tready,
  output logic                  sm_tvalid,
  output logic [DATA_WIDTH-1:0] sm_tdata,
  output logic                  sm_tlast,
  input  logic                  sm_tready,
  output logic                  tap_EN,
  output logic [ADDR_WIDTH-1:0] tap_A,
  input  logic [DATA_WIDTH-1:0] tap_Do,
  output logic                  data_EN,
  output logic [3:0]            data_WE,
  output logic [ADDR_WIDTH-1:0] data_A,
  output logic [DATA_WIDTH-1:0] data_Di,
  input  logic [DATA_WIDTH-1:0] data_Do
);

  localparam int CW = $clog2(TAP_NUM + 1);
  localparam logic [CW-1:0] T_C    = CW'(TAP_NUM);
  localparam logic [CW-1:0] T_LAST = CW'(TAP_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_IN, S_MAC, S_OUT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           len_q, len_d, cnt_q, cnt_d;
  logic [CW-1:0]         wp_q, wp_d, k_q, k_d;
  logic [CW-1:0]         ridx;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, prod;
  logic                  last;
  logic                  unused_tlast;

  assign unused_tlast = ss_tlast;
  assign prod = tap_Do * data_Do;
  assign last = (cnt_q == len_q - 32'd1);
  // Newest sample sits at wp; tap j pairs with the sample j steps older, modulo T.
  assign ridx = (wp_q >= k_q) ? (wp_q - k_q) : (wp_q + T_C - k_q);

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] idx);
    return ADDR_WIDTH'(idx) << 2;
  endfunction

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wp_d      = wp_q;
    k_d       = k_q;
    acc_d     = acc_q;
    ap_done   = 1'b0;
    ap_idle   = 1'b0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tdata  = '0;
    sm_tlast  = 1'b0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;
    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_d = S_INIT;
          len_d   = data_length;
          cnt_d   = '0;
          wp_d    = '0;
          k_d     = '0;
        end
      end
      S_INIT: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(k_q);
        k_d     = k_q + 1'b1;
        if (k_q == T_LAST) begin
          k_d     = '0;
          state_d = (len_q == 32'd0) ? S_DONE : S_IN;
        end
      end
      S_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = word_addr(wp_q);
          data_Di = ss_tdata;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        // Reads issued at step k return at step k+1, so accumulation trails addressing by one.
        if (k_q != T_C) begin
          tap_EN  = 1'b1;
          data_EN = 1'b1;
          tap_A   = word_addr(k_q);
          data_A  = word_addr(ridx);
        end
        if (k_q != '0) acc_d = acc_q + prod;
        if (k_q == T_C) begin
          k_d     = '0;
          state_d = S_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = acc_q;
        sm_tlast  = last;
        if (sm_tready) begin
          cnt_d   = cnt_q + 32'd1;
          wp_d    = (wp_q == T_LAST) ? '0 : wp_q + 1'b1;
          state_d = last ? S_DONE : S_IN;
        end
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/fir_mac_engine.md
FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample/tap/result width.
REQ-002 Parameter ADDR_WIDTH, default 12, byte-address width of tap and data RAM ports.
REQ-003 Parameter TAP_NUM, default 11, number of taps T; T >= 2.
REQ-004 ACLK  in  1  clock; all state updates on rising edge.
REQ-005 ARESET  in  1  reset, synchronous, active-low; clock ACLK.
REQ-006 ap_start  in  1  start request from AXI-lite control slave; ap_done  out  1  one-cycle completion pulse; ap_idle  out  1  engine idle.
REQ-007 data_length  in  32  number of samples to process; sampled when a start is accepted.
REQ-008 ss_tvalid  in  1; ss_tdata  in  DATA_WIDTH; ss_tlast  in  1 (ignored); ss_tready  out  1 -- AXI-Stream sample input.
REQ-009 sm_tvalid  out  1; sm_tdata  out  DATA_WIDTH; sm_tlast  out  1; sm_tready  in  1 -- AXI-Stream result output.
REQ-010 tap_EN  out  1; tap_A  out  ADDR_WIDTH; tap_Do  in  DATA_WIDTH -- read port of tap RAM (written by control slave), 1-cycle read latency.
REQ-011 data_EN  out  1; data_WE  out  4; data_A  out  ADDR_WIDTH; data_Di  out  DATA_WIDTH; data_Do  in  DATA_WIDTH -- data (history) RAM, 1-cycle read latency, write at clock edge.

Function
REQ-012 Word k of either RAM at byte address 4*k; tap i at 4*i.
REQ-013 States: IDLE, INIT, IN, MAC, OUT, DONE; one-hot or encoded, implementer's choice.
REQ-014 IDLE: ap_idle=1; ap_start=1 -> INIT, latch data_length, clear sample counter cnt and write pointer wp.
REQ-015 ap_start while not IDLE ignored.
REQ-016 INIT: exactly T cycles, data_EN=1, data_WE=4'hF, data_Di=0, data_A=4*k for k=0..T-1; then IN, or DONE if latched length = 0.
REQ-017 IN: ss_tready=1 (only state where it is 1); on ss_tvalid: data_WE=4'hF, data_A=4*wp, data_Di=ss_tdata same cycle, -> MAC.
REQ-018 MAC: exactly T+1 cycles; cycle j (0..T-1) drives tap_A=4*j, data_A=4*((wp-j) mod T), enables=1, data_WE=0; cycle j+1 adds tap_Do*data_Do to accumulator; accumulator cleared on MAC entry.
REQ-019 Arithmetic: product and sum truncated to low DATA_WIDTH bits, two's-complement wrap, no saturation.
REQ-020 OUT: sm_tvalid=1, sm_tdata=accumulator, sm_tlast=(cnt == length-1), all stable until sm_tready.
REQ-021 OUT with sm_tready: cnt+1, wp=(wp+1) mod T (T-1 wraps to 0); last -> DONE else IN.
REQ-022 Latency: sample accepted in cycle c -> sm_tvalid first high in cycle c+T+2; max throughput one sample per T+3 cycles.
REQ-023 DONE: ap_done=1 one cycle, ap_idle=0; next cycle IDLE with ap_idle=1.
REQ-024 ap_idle=0 from cycle after start acceptance through DONE.
REQ-025 Outputs not named active in a state are 0 (tap_EN, data_EN, data_WE, ss_tready, sm_tvalid, sm_tlast, ap_done).

Reset
REQ-026 ARESET=0 at any edge, incl. mid-INIT/MAC/OUT: state=IDLE, ap_idle=1, all other outputs 0, accumulator/cnt/wp=0, no ap_done pulse, pending output discarded.

Verification
REQ-027 T=11, taps h[i]=i+1, length=3, inputs 1,0,0 -> outputs 1,2,3; sm_tlast only on 3; ap_done one pulse; ap_idle back to 1 next cycle.
REQ-028 Same taps, length=12, all inputs 1 -> outputs 1,3,6,...,55 (sum 1..n+1), 12th output 66 (wp wrap, oldest sample dropped).
REQ-029 h[0]=32'h7FFFFFFF, others 0, input 2 -> sm_tdata 32'hFFFFFFFE (wrap truncation).
REQ-030 Hold sm_tready=0 for 5 cycles in OUT -> sm_tvalid/sm_tdata/sm_tlast stable, ss_tready=0 throughout; accepted sample at c yields sm_tvalid at c+13.
REQ-031 ARESET low during MAC of sample 2, then restart length=1 input 5 -> output 5 (history zeroed by INIT), no stale ap_done.
REQ-032 length=0, ap_start -> INIT 11 cycles, ap_done pulse, ss_tready and sm_tvalid never asserted; ap_start pulses while busy ignored.
